hazard_ctrl: RTL

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl_if.sv | 32 +++
 rtl/hazard_ctrl.sv | 132 +++++++++++++
 2 files changed

// File: rtl/hazard_ctrl_if.sv
// Pipeline hazard bus: register addresses and enables from the pipeline,
// forwarding/stall/flush controls and event counters back to it.
interface hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       Rs1D, Rs2D;
  logic [4:0]       Rs1E, Rs2E, RdE;
  logic [4:0]       RdM, RdW;
  logic             RegWriteM, RegWriteW;
  logic             LoadE;
  logic             PCSrcE;
  logic             halt_req;
  logic             cnt_clr;
  logic [1:0]       ForwardAE, ForwardBE;
  logic             StallF, StallD, FlushD, FlushE;
  logic             halt_ack;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  modport master (
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
    output RegWriteM, RegWriteW, LoadE, PCSrcE, halt_req, cnt_clr,
    input  ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE,
    input  halt_ack, stall_cnt, flush_cnt
  );

  modport slave (
    input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
    input  RegWriteM, RegWriteW, LoadE, PCSrcE, halt_req, cnt_clr,
    output ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE,
    output halt_ack, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Five-stage pipeline hazard unit: operand forwarding, load-use stall,
// branch flush, debug halt FSM and saturating stall/flush event counters.
module hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic         clk,
  input  logic         rst,
  hazard_ctrl_if.slave bus
);

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             lw_stall_s;
  logic [1:0]       fwd_a_s, fwd_b_s;
  logic             stall_f_s, stall_d_s, flush_d_s, flush_e_s;

  // Memory stage wins over Writeback since it holds the younger result.
  function automatic logic [1:0] fwd_sel(
    input logic [4:0] rs,
    input logic [4:0] rd_m,
    input logic       we_m,
    input logic [4:0] rd_w,
    input logic       we_w
  );
    if (we_m && (rd_m != 5'd0) && (rd_m == rs)) begin
      return 2'b10;
    end else if (we_w && (rd_w != 5'd0) && (rd_w == rs)) begin
      return 2'b01;
    end else begin
      return 2'b00;
    end
  endfunction

  // Forwarding selects and load-use detection
  always_comb begin
    fwd_a_s    = fwd_sel(bus.Rs1E, bus.RdM, bus.RegWriteM, bus.RdW, bus.RegWriteW);
    fwd_b_s    = fwd_sel(bus.Rs2E, bus.RdM, bus.RegWriteM, bus.RdW, bus.RegWriteW);
    lw_stall_s = bus.LoadE && (bus.RdE != 5'd0) &&
                 ((bus.RdE == bus.Rs1D) || (bus.RdE == bus.Rs2D));
  end

  // FSM next state and pipeline control outputs
  always_comb begin
    state_d   = state_q;
    stall_f_s = 1'b0;
    stall_d_s = 1'b0;
    flush_d_s = 1'b0;
    flush_e_s = 1'b0;
    case (state_q)
      RUN: begin
        stall_f_s = lw_stall_s;
        stall_d_s = lw_stall_s;
        flush_d_s = bus.PCSrcE;
        flush_e_s = lw_stall_s || bus.PCSrcE;
        // Only halt on a clean boundary: no pending load-use or redirect.
        if (bus.halt_req && !lw_stall_s && !bus.PCSrcE) begin
          state_d = HALT;
        end else begin
          state_d = RUN;
        end
      end
      HALT: begin
        stall_f_s = 1'b1;
        stall_d_s = 1'b1;
        flush_d_s = 1'b0;
        flush_e_s = 1'b1;
        if (!bus.halt_req) begin
          state_d = RUN;
        end else begin
          state_d = HALT;
        end
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  // Event counter next values; clear overrides increment, no wrap.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (bus.cnt_clr) begin
      stall_cnt_d = '0;
      flush_cnt_d = '0;
    end else begin
      if ((state_q == RUN) && lw_stall_s && (stall_cnt_q != CNT_MAX)) begin
        stall_cnt_d = stall_cnt_q + CNT_ONE;
      end else begin
        stall_cnt_d = stall_cnt_q;
      end
      if ((state_q == RUN) && bus.PCSrcE && (flush_cnt_q != CNT_MAX)) begin
        flush_cnt_d = flush_cnt_q + CNT_ONE;
      end else begin
        flush_cnt_d = flush_cnt_q;
      end
    end
  end

  // State and counter registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= RUN;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign bus.ForwardAE = fwd_a_s;
  assign bus.ForwardBE = fwd_b_s;
  assign bus.StallF    = stall_f_s;
  assign bus.StallD    = stall_d_s;
  assign bus.FlushD    = flush_d_s;
  assign bus.FlushE    = flush_e_s;
  assign bus.halt_ack  = (state_q == HALT);
  assign bus.stall_cnt = stall_cnt_q;
  assign bus.flush_cnt = flush_cnt_q;

endmodule
